rgb_pwm_sequencer: RTL and testbench

- Parametrised multi-channel LED driver; generalises the fixed three-output RGB blinker to CHANNELS outputs with per-channel runtime modes.
- Modes: off, solid PWM, blink and breathe.
- Shared prescaler and PWM counter define PWM frames.
- Per-channel config arrives over a valid/ready write port, is shadowed, and is applied only at frame boundaries so outputs never glitch mid-period.
- Sits between board-level LED pins and any controller, e.g. a UART command decoder or a fixed init ROM.

---
 rtl/led_pkg.sv | 24 ++
 rtl/rgb_pwm_sequencer_if.sv | 26 ++
 rtl/led_channel.sv | 111 +++++++++++
 rtl/rgb_pwm_sequencer.sv | 82 ++++++++
 tb/tb_rgb_pwm_sequencer.sv | 196 +++++++++++++++++++
 5 files changed

// File: rtl/led_pkg.sv
// Shared types for the RGB/PWM LED sequencer: channel modes and per-channel
// blink/breathe state encodings.
package led_pkg;

  localparam int unsigned MODE_W = 2;

  typedef enum logic [MODE_W-1:0] {
    MODE_OFF     = 2'd0,
    MODE_SOLID   = 2'd1,
    MODE_BLINK   = 2'd2,
    MODE_BREATHE = 2'd3
  } led_mode_t;

  typedef enum logic {
    DIR_UP   = 1'b0,
    DIR_DOWN = 1'b1
  } ramp_dir_t;

  typedef enum logic {
    PHASE_ON  = 1'b0,
    PHASE_OFF = 1'b1
  } blink_phase_t;

endpackage

// File: rtl/rgb_pwm_sequencer_if.sv
// Config write port of the LED sequencer: valid/ready write plus error pulse.
interface rgb_pwm_sequencer_if #(
  parameter int unsigned CHANNELS = 3,
  parameter int unsigned PWM_BITS = 8
);

  localparam int unsigned CHAN_W = (CHANNELS > 1) ? $clog2(CHANNELS) : 1;

  logic                      cfg_valid;
  logic                      cfg_ready;
  logic [CHAN_W-1:0]         cfg_chan;
  logic [led_pkg::MODE_W-1:0] cfg_mode;
  logic [PWM_BITS-1:0]       cfg_level;
  logic                      cfg_err;

  modport master (
    output cfg_valid, cfg_chan, cfg_mode, cfg_level,
    input  cfg_ready, cfg_err
  );

  modport slave (
    input  cfg_valid, cfg_chan, cfg_mode, cfg_level,
    output cfg_ready, cfg_err
  );

endinterface

// File: rtl/led_channel.sv
// One LED channel: shadowed config, frame-boundary apply, and per-frame duty
// generation for OFF / SOLID / BLINK / BREATHE.
module led_channel
  import led_pkg::*;
#(
  parameter int unsigned PWM_BITS     = 8,
  parameter int unsigned BLINK_FRAMES = 32
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                frame_wrap,
  input  logic                wr_en,
  input  led_mode_t           wr_mode,
  input  logic [PWM_BITS-1:0] wr_level,
  output logic [PWM_BITS-1:0] duty
);

  localparam int unsigned BF_W = (BLINK_FRAMES > 1) ? $clog2(BLINK_FRAMES) : 1;

  led_mode_t           pend_mode_q, pend_mode_d, mode_q, mode_d;
  logic [PWM_BITS-1:0] pend_level_q, pend_level_d, level_q, level_d;
  logic [PWM_BITS-1:0] ramp_q, ramp_d, duty_q, duty_d;
  logic                dirty_q, dirty_d;
  ramp_dir_t           dir_q, dir_d;
  blink_phase_t        phase_q, phase_d;
  logic [BF_W-1:0]     bcnt_q, bcnt_d;

  always_comb begin
    pend_mode_d  = pend_mode_q;
    pend_level_d = pend_level_q;
    dirty_d      = dirty_q;
    mode_d       = mode_q;
    level_d      = level_q;
    ramp_d       = ramp_q;
    dir_d        = dir_q;
    phase_d      = phase_q;
    bcnt_d       = bcnt_q;
    duty_d       = duty_q;

    if (frame_wrap) begin
      if (dirty_q) begin
        mode_d  = pend_mode_q;
        level_d = pend_level_q;
        dirty_d = 1'b0;
        ramp_d  = '0;
        dir_d   = DIR_UP;
        phase_d = PHASE_ON;
        bcnt_d  = '0;
      end else begin
        if (bcnt_q == BF_W'(BLINK_FRAMES - 1)) begin
          bcnt_d  = '0;
          phase_d = (phase_q == PHASE_ON) ? PHASE_OFF : PHASE_ON;
        end else begin
          bcnt_d = bcnt_q + 1'b1;
        end
        // Step first, then turn around on the new value so ramp stays in [0, level].
        if (dir_q == DIR_UP) begin
          if (ramp_q < level_q) ramp_d = ramp_q + 1'b1;
          if (ramp_d == level_q) dir_d = DIR_DOWN;
        end else begin
          if (ramp_q != '0) ramp_d = ramp_q - 1'b1;
          if (ramp_d == '0) dir_d = DIR_UP;
        end
      end

      unique case (mode_d)
        MODE_OFF:     duty_d = '0;
        MODE_SOLID:   duty_d = level_d;
        MODE_BLINK:   duty_d = (phase_d == PHASE_ON) ? level_d : '0;
        MODE_BREATHE: duty_d = ramp_d;
        default:      duty_d = '0;
      endcase
    end

    // A write on the apply edge lands in the shadow for the following frame.
    if (wr_en) begin
      pend_mode_d  = wr_mode;
      pend_level_d = wr_level;
      dirty_d      = 1'b1;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      pend_mode_q  <= MODE_OFF;
      pend_level_q <= '0;
      dirty_q      <= 1'b0;
      mode_q       <= MODE_OFF;
      level_q      <= '0;
      ramp_q       <= '0;
      dir_q        <= DIR_UP;
      phase_q      <= PHASE_ON;
      bcnt_q       <= '0;
      duty_q       <= '0;
    end else begin
      pend_mode_q  <= pend_mode_d;
      pend_level_q <= pend_level_d;
      dirty_q      <= dirty_d;
      mode_q       <= mode_d;
      level_q      <= level_d;
      ramp_q       <= ramp_d;
      dir_q        <= dir_d;
      phase_q      <= phase_d;
      bcnt_q       <= bcnt_d;
      duty_q       <= duty_d;
    end
  end

  assign duty = duty_q;

endmodule

// File: rtl/rgb_pwm_sequencer.sv
// Multi-channel LED PWM sequencer: shared prescaler and PWM frame counter,
// config write decode, and registered per-channel output compare.
module rgb_pwm_sequencer
  import led_pkg::*;
#(
  parameter int unsigned CHANNELS     = 3,
  parameter int unsigned PWM_BITS     = 8,
  parameter int unsigned PRESCALE     = 1,
  parameter int unsigned BLINK_FRAMES = 32,
  parameter bit          ACTIVE_LOW   = 1'b1
) (
  input  logic                clk,
  input  logic                rst,
  rgb_pwm_sequencer_if.slave  cfg,
  output logic                frame_tick,
  output logic [CHANNELS-1:0] led
);

  localparam int unsigned PRE_W = (PRESCALE > 1) ? $clog2(PRESCALE) : 1;

  logic [PRE_W-1:0]    presc_q, presc_d;
  logic [PWM_BITS-1:0] pwm_cnt_q, pwm_cnt_d;
  logic                tick, wrap, accept, chan_ok;
  logic                ready_q, err_q, err_d, frame_tick_q;
  logic [CHANNELS-1:0] led_q, led_d, wr_en;
  logic [PWM_BITS-1:0] duty [CHANNELS];

  always_comb begin
    tick      = (presc_q == PRE_W'(PRESCALE - 1));
    presc_d   = tick ? '0 : presc_q + 1'b1;
    pwm_cnt_d = tick ? pwm_cnt_q + 1'b1 : pwm_cnt_q;
    wrap      = tick && (pwm_cnt_q == '1);
    accept    = cfg.cfg_valid && ready_q;
    chan_ok   = (32'(cfg.cfg_chan) < CHANNELS);
    err_d     = accept && !chan_ok;
    wr_en     = '0;
    led_d     = '0;
    for (int unsigned i = 0; i < CHANNELS; i++) begin
      wr_en[i] = accept && chan_ok && (32'(cfg.cfg_chan) == i);
      led_d[i] = (pwm_cnt_q < duty[i]) ^ ACTIVE_LOW;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      presc_q      <= '0;
      pwm_cnt_q    <= '0;
      ready_q      <= 1'b0;
      err_q        <= 1'b0;
      frame_tick_q <= 1'b0;
      led_q        <= {CHANNELS{ACTIVE_LOW}};
    end else begin
      presc_q      <= presc_d;
      pwm_cnt_q    <= pwm_cnt_d;
      ready_q      <= 1'b1;
      err_q        <= err_d;
      frame_tick_q <= wrap;
      led_q        <= led_d;
    end
  end

  for (genvar g = 0; g < CHANNELS; g++) begin : g_chan
    led_channel #(
      .PWM_BITS    (PWM_BITS),
      .BLINK_FRAMES(BLINK_FRAMES)
    ) u_chan (
      .clk       (clk),
      .rst       (rst),
      .frame_wrap(wrap),
      .wr_en     (wr_en[g]),
      .wr_mode   (led_mode_t'(cfg.cfg_mode)),
      .wr_level  (cfg.cfg_level),
      .duty      (duty[g])
    );
  end

  assign cfg.cfg_ready = ready_q;
  assign cfg.cfg_err   = err_q;
  assign frame_tick    = frame_tick_q;
  assign led           = led_q;

endmodule

// File: tb/tb_rgb_pwm_sequencer.sv
// Directed bench for rgb_pwm_sequencer with 16-tick frames and 2-frame blink.
module tb_rgb_pwm_sequencer;

  localparam int unsigned CH = 3;
  localparam int unsigned PB = 4;

  logic          clk = 1'b0;
  logic          rst = 1'b0;
  logic          frame_tick;
  logic [CH-1:0] led;

  int n_cmp  = 0;
  int n_fail = 0;

  rgb_pwm_sequencer_if #(.CHANNELS(CH), .PWM_BITS(PB)) cfg_if ();

  rgb_pwm_sequencer #(
    .CHANNELS    (CH),
    .PWM_BITS    (PB),
    .PRESCALE    (1),
    .BLINK_FRAMES(2),
    .ACTIVE_LOW  (1'b1)
  ) dut (
    .clk       (clk),
    .rst       (rst),
    .cfg       (cfg_if),
    .frame_tick(frame_tick),
    .led       (led)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic write_cfg(input logic [1:0] ch, input logic [1:0] mode, input logic [3:0] lvl);
    cfg_if.cfg_valid = 1'b1;
    cfg_if.cfg_chan  = ch;
    cfg_if.cfg_mode  = mode;
    cfg_if.cfg_level = lvl;
    @(negedge clk);
    cfg_if.cfg_valid = 1'b0;
  endtask

  // Advance to the next negedge where frame_tick is high, bounded to 40 cycles.
  task automatic wait_ft(output bit ok, output logic [2:0] lowm, output int ncyc);
    ok = 1'b0;
    lowm = '0;
    ncyc = 0;
    for (int i = 0; i < 40; i++) begin
      @(negedge clk);
      ncyc++;
      lowm = lowm | ~led;
      if (frame_tick) begin
        ok = 1'b1;
        break;
      end
    end
  endtask

  // Starting at a frame_tick negedge, sample the following 16 cycles (one frame).
  task automatic measure(output logic [15:0] p0, output logic [15:0] p1,
                         output logic [15:0] p2, output logic [15:0] ftp);
    p0 = '0; p1 = '0; p2 = '0; ftp = '0;
    for (int k = 0; k < 16; k++) begin
      @(negedge clk);
      p0[k]  = ~led[0];
      p1[k]  = ~led[1];
      p2[k]  = ~led[2];
      ftp[k] = frame_tick;
    end
  endtask

  initial begin
    bit          ok;
    logic [2:0]  lowm;
    int          ncyc;
    logic [15:0] p0, p1, p2, ftp;
    int          exp_blink [5]   = '{15, 15, 0, 0, 15};
    int          exp_ramp  [10]  = '{0, 1, 2, 3, 2, 1, 0, 1, 2, 3};
    int          exp_blink2[10]  = '{0, 0, 15, 15, 0, 0, 15, 15, 0, 0};

    cfg_if.cfg_valid = 1'b0;
    cfg_if.cfg_chan  = '0;
    cfg_if.cfg_mode  = '0;
    cfg_if.cfg_level = '0;

    #1 rst = 1'b1;
    #1;
    check("rst_led", 32'(led), 32'h7);
    check("rst_ready", 32'(cfg_if.cfg_ready), 32'h0);
    check("rst_err", 32'(cfg_if.cfg_err), 32'h0);
    check("rst_ftick", 32'(frame_tick), 32'h0);

    repeat (2) @(negedge clk);
    rst = 1'b0;
    #1 check("ready_at_release", 32'(cfg_if.cfg_ready), 32'h0);
    @(negedge clk);
    check("ready_after_1", 32'(cfg_if.cfg_ready), 32'h1);
    wait_ft(ok, lowm, ncyc);
    check("first_ftick_seen", 32'(ok), 32'h1);
    check("first_ftick_delay", 32'(ncyc + 1), 32'd16);
    check("idle_low_mask", 32'(lowm), 32'h0);
    measure(p0, p1, p2, ftp);
    check("idle_led", 32'({p2, p1, p0} != '0), 32'h0);
    check("idle_ftick_period", 32'(ftp), 32'h8000);

    // SOLID ch0 level 4 written mid-frame
    repeat (5) @(negedge clk);
    write_cfg(2'd0, 2'd1, 4'd4);
    wait_ft(ok, lowm, ncyc);
    check("solid_wait_ok", 32'(ok), 32'h1);
    check("solid_no_early", 32'(lowm[0]), 32'h0);
    for (int f = 0; f < 2; f++) begin
      measure(p0, p1, p2, ftp);
      check("solid_pattern", 32'(p0), 32'h000F);
      check("solid_ftick", 32'(ftp), 32'h8000);
    end

    // BLINK ch1 level 15
    write_cfg(2'd1, 2'd2, 4'd15);
    wait_ft(ok, lowm, ncyc);
    check("blink_wait_ok", 32'(ok), 32'h1);
    check("blink_no_early", 32'(lowm[1]), 32'h0);
    for (int f = 0; f < 5; f++) begin
      measure(p0, p1, p2, ftp);
      check("blink_low_count", 32'($countones(p1)), 32'(exp_blink[f]));
      check("blink_ch0_kept", 32'(p0), 32'h000F);
    end

    // BREATHE ch2 level 3
    write_cfg(2'd2, 2'd3, 4'd3);
    wait_ft(ok, lowm, ncyc);
    check("breathe_wait_ok", 32'(ok), 32'h1);
    check("breathe_no_early", 32'(lowm[2]), 32'h0);
    for (int f = 0; f < 10; f++) begin
      measure(p0, p1, p2, ftp);
      check("breathe_low_count", 32'($countones(p2)), 32'(exp_ramp[f]));
      check("breathe_blink_count", 32'($countones(p1)), 32'(exp_blink2[f]));
    end

    // Out-of-range channel write
    write_cfg(2'd3, 2'd1, 4'd8);
    check("err_pulse", 32'(cfg_if.cfg_err), 32'h1);
    @(negedge clk);
    check("err_one_cycle", 32'(cfg_if.cfg_err), 32'h0);
    wait_ft(ok, lowm, ncyc);
    check("err_wait_ok", 32'(ok), 32'h1);
    measure(p0, p1, p2, ftp);
    check("err_ch0_kept", 32'(p0), 32'h000F);
    check("err_ch1_blink", 32'($countones(p1)), 32'd15);
    check("err_ch2_ramp", 32'($countones(p2)), 32'd1);

    // Two ch0 writes in one frame: last one wins
    cfg_if.cfg_valid = 1'b1;
    cfg_if.cfg_chan  = 2'd0;
    cfg_if.cfg_mode  = 2'd1;
    cfg_if.cfg_level = 4'd2;
    @(negedge clk);
    cfg_if.cfg_level = 4'd9;
    @(negedge clk);
    cfg_if.cfg_valid = 1'b0;
    check("no_err_valid_writes", 32'(cfg_if.cfg_err), 32'h0);
    wait_ft(ok, lowm, ncyc);
    check("last_wait_ok", 32'(ok), 32'h1);
    measure(p0, p1, p2, ftp);
    check("last_write_wins", 32'(p0), 32'h01FF);
    check("last_ch1_blink", 32'($countones(p1)), 32'd0);
    check("last_ch2_ramp", 32'($countones(p2)), 32'd1);

    // Asynchronous reset mid-frame with all channels active
    repeat (5) @(negedge clk);
    check("pre_rst_led", 32'(led), 32'h4);
    #1 rst = 1'b1;
    #1;
    check("async_rst_led", 32'(led), 32'h7);
    check("async_rst_ready", 32'(cfg_if.cfg_ready), 32'h0);
    repeat (2) @(negedge clk);
    rst = 1'b0;
    wait_ft(ok, lowm, ncyc);
    check("post_rst_ftick", 32'(ncyc), 32'd16);
    check("post_rst_low_mask", 32'(lowm), 32'h0);
    measure(p0, p1, p2, ftp);
    check("post_rst_all_off", 32'({p2, p1, p0} != '0), 32'h0);
    check("post_rst_ftick_period", 32'(ftp), 32'h8000);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
